// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types, width defaults and signed clamp helper for the pipeline datapath
package pipeline_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 40;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } clamp_t;

    // Works on a 64-bit sign-extended value so any AW/DW pair up to 64 bits can share it.
    function automatic clamp_t clamp_signed(input logic signed [63:0] v, input int dw);
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        clamp_t r;
        maxv = (64'sd1 <<< (dw - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (dw - 1));
        r.sat = 1'b0;
        r.val = v;
        if (v > maxv) begin
            r.sat = 1'b1;
            r.val = maxv;
        end else if (v < minv) begin
            r.sat = 1'b1;
            r.val = minv;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_accumulator_if.sv
// rtl/dot_accumulator_if.sv - term input and vector-sum output handshake bundle
interface dot_accumulator_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic          out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_sat
    );
endinterface

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - combinational signed clamp of an AW-bit sum down to DW bits with a saturation flag
module sat_clamp
    import pipeline_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic signed [AW-1:0] sum,
    output logic        [DW-1:0] clamped,
    output logic                 sat
);
    clamp_t r;

    always_comb r = clamp_signed(64'(sum), DW);

    assign clamped = DW'(r.val);
    assign sat     = r.sat;
endmodule

// File: rtl/dot_accumulator.sv
// rtl/dot_accumulator.sv - accumulates LEN signed terms into one vector sum; DOT_ACC_SAT_EN selects clamping over wrap
module dot_accumulator
    import pipeline_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int AW  = AW_DEFAULT,
    parameter int LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    dot_accumulator_if.slave  bus
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum_nx;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;
    logic          out_hs;
    logic [DW-1:0] load_sum;
    logic          load_sat;
    logic [DW-1:0] out_sum_r;
    logic          out_sat_r;

    assign accept = bus.in_valid & bus.in_ready;
    assign last   = accept && (cnt == CW'(LEN - 1));
    assign out_hs = bus.out_valid & bus.out_ready;
    assign sum_nx = acc + {{(AW-DW){bus.in_data[DW-1]}}, bus.in_data};

`ifdef DOT_ACC_SAT_EN
    sat_clamp #(.DW(DW), .AW(AW)) u_clamp (
        .sum     (sum_nx),
        .clamped (load_sum),
        .sat     (load_sat)
    );
`else
    assign load_sum = sum_nx[DW-1:0];
    assign load_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) state <= ACCUM;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (last)   state_nx = OUT;
            OUT:     if (out_hs) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACCUM);
        bus.out_valid = (state == OUT);
    end

    // clr wipes everything rst does, and outranks any same-cycle accept or handshake.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc       <= '0;
            cnt       <= '0;
            out_sum_r <= '0;
            out_sat_r <= 1'b0;
        end else begin
            if (accept) begin
                acc <= sum_nx;
                if (last) begin
                    cnt       <= '0;
                    out_sum_r <= load_sum;
                    out_sat_r <= load_sat;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (out_hs) acc <= '0;
        end
    end

    assign bus.out_sum = out_sum_r;
    assign bus.out_sat = out_sat_r;
endmodule

// File: tb/tb_dot_accumulator.sv
// tb/tb_dot_accumulator.sv - directed self-checking bench for dot_accumulator (LEN=4)
module tb_dot_accumulator;
    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    dot_accumulator_if #(.DW(32)) bus ();

    dot_accumulator #(.DW(32), .AW(40), .LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        check("term_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_out(input string tag, input logic [31:0] sum, input logic sat);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_sum"}, 64'(bus.out_sum), 64'(sum));
        check({tag, "_sat"}, 64'(bus.out_sat), 64'(sat));
        check({tag, "_inrdy"}, 64'(bus.in_ready), 64'd0);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        step();
        check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.out_sum), 64'd0);
        check("rst_sat", 64'(bus.out_sat), 64'd0);
        check("rst_inrdy", 64'(bus.in_ready), 64'd1);

        // back-to-back vector, out_ready held high: one-cycle out_valid
        bus.out_ready = 1'b1;
        feed(32'd6); feed(32'd6); feed(-32'sd2); feed(32'd5);
        expect_out("b2b", 32'd15, 1'b0);
        step();
        check("b2b_onecycle", 64'(bus.out_valid), 64'd0);
        check("b2b_inrdy_back", 64'(bus.in_ready), 64'd1);

        // backpressure: result held, held term not taken
        bus.out_ready = 1'b0;
        feed(32'd6); feed(32'd6); feed(-32'sd2); feed(32'd5);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd99;
        for (int i = 0; i < 5; i++) begin
            expect_out("bp_hold", 32'd15, 1'b0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_released", 64'(bus.out_valid), 64'd0);
        feed(32'd1); feed(32'd1); feed(32'd1); feed(32'd1);
        expect_out("bp_next", 32'd4, 1'b0);
        step();

        // bubbles: gaps must not advance the term count
        feed(32'd10); gap(3); feed(32'd20); gap(1); feed(32'd30);
        check("bub_early", 64'(bus.out_valid), 64'd0);
        feed(32'd40);
        expect_out("bub", 32'd100, 1'b0);
        step();

        // clr in ACCUM discards the partial 7+8
        feed(32'd7); feed(32'd8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        bus.out_ready = 1'b0;
        feed(32'd1); feed(32'd2); feed(32'd3); feed(32'd4);
        expect_out("clr_acc", 32'd10, 1'b0);
        // clr in OUT drops the result without a handshake
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_out_valid", 64'(bus.out_valid), 64'd0);
        check("clr_out_inrdy", 64'(bus.in_ready), 64'd1);

        // overflow of the DW range
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed(32'h7FFF_FFFF);
`ifdef DOT_ACC_SAT_EN
        expect_out("ovf_pos", 32'h7FFF_FFFF, 1'b1);
`else
        expect_out("ovf_pos", 32'hFFFF_FFFC, 1'b0);
`endif
        step();
        feed(32'h8000_0000); feed(32'h8000_0000); feed(32'd0); feed(32'd0);
`ifdef DOT_ACC_SAT_EN
        expect_out("ovf_neg", 32'h8000_0000, 1'b1);
`else
        expect_out("ovf_neg", 32'h0000_0000, 1'b0);
`endif
        drain("ovf_neg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
